// File: rtl/hex_disp_pkg.sv
// ============================================================================
// Module  : hex_disp_pkg
// Brief   : Shared widths, types and helpers for the HEX5..HEX3 display path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_disp_pkg;

  localparam int HEX_DIGITS = 3;
  localparam int SEG_W      = 7;
  localparam int WORD_W     = HEX_DIGITS * SEG_W;

  typedef logic [SEG_W-1:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;

  function automatic seg7_t seg_field(input logic [WORD_W-1:0] word, input int d);
    return word[d*SEG_W +: SEG_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_pwm_gen.sv
// ============================================================================
// Module  : hex_pwm_gen
// Brief   : PWM prescaler, step counter, frame tick and effective brightness.
//           HEX_FADE_EN: eff_bright ramps one step per frame instead of jumping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_pwm_gen #(
  parameter int PWM_PRESCALE = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] brightness_i,
  output logic       on_o,
  output logic       frame_tick_o
);

  localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_PRESCALE - 1);

  logic [PS_W-1:0] presc_q, presc_d;
  logic [3:0]      pwm_cnt_q, pwm_cnt_d;
  logic [3:0]      eff_bright_q, eff_bright_d;
  logic            frame_tick_q;
  logic            step;
  logic            wrap;

  always_comb begin
    step         = (presc_q == PS_LAST);
    wrap         = step && (pwm_cnt_q == 4'hF);
    presc_d      = step ? '0 : presc_q + 1'b1;
    pwm_cnt_d    = step ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
    eff_bright_d = eff_bright_q;
    // Brightness is only sampled at the frame boundary so a frame never tears.
    if (wrap) begin
`ifdef HEX_FADE_EN
      if (eff_bright_q < brightness_i) begin
        eff_bright_d = eff_bright_q + 4'd1;
      end else if (eff_bright_q > brightness_i) begin
        eff_bright_d = eff_bright_q - 4'd1;
      end
`else
      eff_bright_d = brightness_i;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      pwm_cnt_q    <= 4'd0;
      eff_bright_q <= 4'd0;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pwm_cnt_q    <= pwm_cnt_d;
      eff_bright_q <= eff_bright_d;
      frame_tick_q <= wrap;
    end
  end

  assign on_o         = (eff_bright_q == 4'hF) | (pwm_cnt_q < eff_bright_q);
  assign frame_tick_o = frame_tick_q;

endmodule

`default_nettype wire

// File: rtl/hex_seg_pwm_driver.sv
// ============================================================================
// Module  : hex_seg_pwm_driver
// Brief   : PWM dimming and per-digit blink for the HEX5..HEX3 segment word.
//           Optional HEX_FADE_EN makes brightness changes ramp one step/frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_seg_pwm_driver
  import hex_disp_pkg::*;
#(
  parameter int PWM_PRESCALE   = 64,
  parameter int BLINK_HALF     = 25_000_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     seg_word,
  input  logic [3:0]            brightness,
  input  logic [HEX_DIGITS-1:0] blink_mask,
  output logic [SEG_W-1:0]      hex3,
  output logic [SEG_W-1:0]      hex4,
  output logic [SEG_W-1:0]      hex5,
  output logic                  frame_tick
);

  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

  logic [WORD_W-1:0]     seg_q;
  logic [3:0]            brightness_q;
  logic [HEX_DIGITS-1:0] blink_mask_q;
  logic [BL_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [WORD_W-1:0]     lit_q, lit_d;
  logic [WORD_W-1:0]     pins;
  logic                  on;

  hex_pwm_gen #(
    .PWM_PRESCALE (PWM_PRESCALE)
  ) u_pwm (
    .clk          (clk),
    .reset        (reset),
    .brightness_i (brightness_q),
    .on_o         (on),
    .frame_tick_o (frame_tick)
  );

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BL_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  for (genvar d = 0; d < HEX_DIGITS; d++) begin : g_digit
    assign lit_d[d*SEG_W +: SEG_W] =
      seg_field(seg_q, d) & {SEG_W{on & ~(blink_mask_q[d] & blink_phase_q)}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q         <= '0;
      brightness_q  <= 4'd0;
      blink_mask_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      lit_q         <= {HEX_DIGITS{SEG_BLANK}};
    end else begin
      seg_q         <= seg_word;
      brightness_q  <= brightness;
      blink_mask_q  <= blink_mask;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      lit_q         <= lit_d;
    end
  end

  assign pins = (SEG_ACTIVE_LOW != 0) ? ~lit_q : lit_q;
  assign hex3 = seg_field(pins, 0);
  assign hex4 = seg_field(pins, 1);
  assign hex5 = seg_field(pins, 2);

endmodule

`default_nettype wire
